coin_validator: RTL and testbench

- Upstream stage of the vending FSM. Conditions the raw light-barrier coin sensor: synchronise, debounce, measure pulse width.
- Classifies each coin as 50 ct, 1 EUR or invalid.
- Emits a one-cycle 2-bit coin code in exactly the encoding the vending FSM consumes on its coin input: 01 = 50 ct, 10 = 1 EUR, 00 = none.

---
 rtl/coin_pkg.sv | 18 +
 rtl/coin_debounce.sv | 61 ++++++
 rtl/coin_validator.sv | 126 ++++++++++++
 tb/tb_coin_validator.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared coin-path types: the coin code driven to the vending FSM and the validator state encoding.
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_50   = 2'b01,
    COIN_100  = 2'b10
  } coin_code_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MEASURE  = 3'd1,
    CLASSIFY = 3'd2,
    JAM      = 3'd3,
    LOCKOUT  = 3'd4
  } cv_state_t;

endpackage

// File: rtl/coin_debounce.sv
// Sensor synchroniser + debouncer; both edges of deb lag sens by SYNC_STAGES+DEB_CYCLES cycles.
// No backpressure. deb_rise is suppressed until the line has been seen stably low after reset.
module coin_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sens,
  output logic deb,
  output logic deb_rise,
  output logic deb_fall
);

  localparam int DCW = $clog2(DEB_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic [DCW-1:0]         stab_cnt;
  logic [DCW-1:0]         low_cnt;
  logic                   armed;
  logic                   samp;
  logic                   toggle;

  assign samp   = sync_q[SYNC_STAGES-1];
  assign toggle = (samp != deb) && (stab_cnt == DCW'(DEB_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      fill_q   <= '0;
      stab_cnt <= '0;
      low_cnt  <= '0;
      armed    <= 1'b0;
      deb      <= 1'b0;
      deb_rise <= 1'b0;
      deb_fall <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], sens};
      fill_q   <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      if (samp == deb || toggle)
        stab_cnt <= '0;
      else
        stab_cnt <= stab_cnt + 1'b1;
      if (toggle)
        deb <= ~deb;
      deb_rise <= toggle && !deb && armed;
      deb_fall <= toggle && deb;
      // A sensor already blocked when reset releases must go low before a coin is accepted.
      if (!armed) begin
        if (!fill_q[SYNC_STAGES-1] || samp || deb)
          low_cnt <= '0;
        else if (low_cnt == DCW'(DEB_CYCLES - 1))
          armed <= 1'b1;
        else
          low_cnt <= low_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/coin_validator.sv
// Coin validator: debounce, width-measure and classify; coin_o/reject_o one cycle after CLASSIFY.
// No backpressure. Define COIN_VALIDATOR_STATS_EN to add saturating accept/reject counters.
module coin_validator
  import coin_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int CNT_W       = 8,
  parameter int W50_MIN     = 20,
  parameter int W50_MAX     = 40,
  parameter int W100_MIN    = 60,
  parameter int W100_MAX    = 90,
  parameter int LOCK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sens_i,
  input  logic       inhibit_i,
  output logic [1:0] coin_o,
  output logic       reject_o,
  output logic       jam_o,
  output logic       busy_o
`ifdef COIN_VALIDATOR_STATS_EN
  ,
  output logic [7:0] acc_cnt_o,
  output logic [7:0] rej_cnt_o
`endif
);

  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             deb;
  logic             deb_rise;
  logic             deb_fall;
  cv_state_t        state;
  cv_state_t        state_nxt;
  logic [CNT_W-1:0] w_cnt;
  logic [LW-1:0]    lock_cnt;
  coin_code_t       coin_q;
  coin_code_t       coin_nxt;
  logic             rej_q;
  logic             rej_nxt;
  logic             in_50;
  logic             in_100;

  coin_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk     (clk),
    .rst     (rst),
    .sens    (sens_i),
    .deb     (deb),
    .deb_rise(deb_rise),
    .deb_fall(deb_fall)
  );

  assign in_50  = (w_cnt >= CNT_W'(W50_MIN))  && (w_cnt <= CNT_W'(W50_MAX));
  assign in_100 = (w_cnt >= CNT_W'(W100_MIN)) && (w_cnt <= CNT_W'(W100_MAX));

  always_comb begin
    state_nxt = state;
    coin_nxt  = COIN_NONE;
    rej_nxt   = 1'b0;
    case (state)
      IDLE:    if (deb_rise) state_nxt = MEASURE;
      // Jump one cycle early so JAM is entered as the counter lands on its ceiling.
      MEASURE: if (deb_fall) state_nxt = CLASSIFY;
               else if (deb && w_cnt == CNT_MAX - 1'b1) state_nxt = JAM;
      CLASSIFY: begin
        state_nxt = LOCKOUT;
        if (inhibit_i)   rej_nxt  = 1'b1;
        else if (in_50)  coin_nxt = COIN_50;
        else if (in_100) coin_nxt = COIN_100;
        else             rej_nxt  = 1'b1;
      end
      JAM:     if (deb_fall) state_nxt = LOCKOUT;
      LOCKOUT: if (lock_cnt == LW'(LOCK_CYCLES - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      w_cnt    <= '0;
      lock_cnt <= '0;
      coin_q   <= COIN_NONE;
      rej_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      coin_q <= coin_nxt;
      rej_q  <= rej_nxt;
      // The rise cycle is itself the first high cycle, so w equals the pulse width at the fall.
      if (deb_rise)
        w_cnt <= CNT_W'(1);
      else if (deb && w_cnt != CNT_MAX)
        w_cnt <= w_cnt + 1'b1;
      if (state == LOCKOUT)
        lock_cnt <= lock_cnt + 1'b1;
      else
        lock_cnt <= '0;
    end
  end

  assign coin_o   = coin_q;
  assign reject_o = rej_q;
  assign jam_o    = (state == JAM);
  assign busy_o   = (state != IDLE);

`ifdef COIN_VALIDATOR_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt_o <= '0;
      rej_cnt_o <= '0;
    end else begin
      if (coin_nxt != COIN_NONE && acc_cnt_o != 8'hFF)
        acc_cnt_o <= acc_cnt_o + 1'b1;
      if ((rej_nxt || (state == MEASURE && state_nxt == JAM)) && rej_cnt_o != 8'hFF)
        rej_cnt_o <= rej_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_coin_validator.sv
// Self-checking bench for coin_validator: vector table, corner sequences, random run vs width model.
module tb_coin_validator;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LOCK = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sens_i = 1'b0;
  logic       inhibit_i = 1'b0;
  logic [1:0] coin_o;
  logic       reject_o;
  logic       jam_o;
  logic       busy_o;
`ifdef COIN_VALIDATOR_STATS_EN
  logic [7:0] acc_cnt_o;
  logic [7:0] rej_cnt_o;
`endif

  coin_validator dut (
    .clk      (clk),
    .rst      (rst),
    .sens_i   (sens_i),
    .inhibit_i(inhibit_i),
    .coin_o   (coin_o),
    .reject_o (reject_o),
    .jam_o    (jam_o),
    .busy_o   (busy_o)
`ifdef COIN_VALIDATOR_STATS_EN
    ,
    .acc_cnt_o(acc_cnt_o),
    .rej_cnt_o(rej_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Output monitor: monotonic totals, the bench works on differences.
  int  cyc = 0;
  int  n50 = 0, n100 = 0, nrej = 0, nbad = 0, njam = 0, busy_cycles = 0;
  int  last_pulse_cyc = 0, busy_rise_cyc = 0, busy_fall_cyc = 0, jam_rise_cyc = 0;
  bit  prev_pulse = 0, prev_busy = 0, prev_jam = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (coin_o == 2'b01) n50 = n50 + 1;
    if (coin_o == 2'b10) n100 = n100 + 1;
    if (reject_o) nrej = nrej + 1;
    if (coin_o != 2'b00 || reject_o) begin
      if (prev_pulse) nbad = nbad + 1;
      if (coin_o != 2'b00 && reject_o) nbad = nbad + 1;
      if (coin_o == 2'b11) nbad = nbad + 1;
      last_pulse_cyc = cyc;
    end
    prev_pulse = (coin_o != 2'b00) || reject_o;
    if (busy_o && !prev_busy) busy_rise_cyc = cyc;
    if (!busy_o && prev_busy) busy_fall_cyc = cyc;
    prev_busy = busy_o;
    if (busy_o) busy_cycles = busy_cycles + 1;
    if (jam_o && !prev_jam) begin
      jam_rise_cyc = cyc;
      njam = njam + 1;
    end
    prev_jam = jam_o;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: classification purely from pulse width and inhibit.
  int exp_acc = 0, exp_rej = 0;

  function automatic int model_code(input int w, input bit inh);
    // 0 none, 1 = 50 ct, 2 = 1 EUR, 3 = reject
    if (w < DEB) return 0;
    if (w >= 255) return 0;
    if (inh) return 3;
    if (w >= 20 && w <= 40) return 1;
    if (w >= 60 && w <= 90) return 2;
    return 3;
  endfunction

  task automatic note_model(input int code);
    if ((code == 1 || code == 2) && exp_acc < 255) exp_acc++;
    if (code == 3 && exp_rej < 255) exp_rej++;
  endtask

  task automatic drive_pulse(input int w);
    @(posedge clk); #1 sens_i = 1'b1;
    repeat (w) @(posedge clk);
    #1 sens_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    repeat (SYNC + DEB + 2) @(posedge clk);
    @(negedge clk);
    k = 0;
    while (busy_o && k < 80) begin
      @(negedge clk);
      k++;
    end
    if (busy_o) check({name, "_idle_timeout"}, 1, 0);
    repeat (3) @(posedge clk);
  endtask

  int s50, s100, srej, sbad, sbusy, sjam;
  task automatic snap();
    s50 = n50; s100 = n100; srej = nrej; sbad = nbad; sbusy = busy_cycles; sjam = njam;
  endtask

  typedef struct {
    int width;
    bit inh;
    int e50;
    int e100;
    int erej;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int w, code;
    bit inh;
    string nm;

    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, code;
    bit inh;
    string nm;

    vecs[0]  = '{30, 1'b0, 1, 0, 0};
    vecs[1]  = '{75, 1'b0, 0, 1, 0};
    vecs[2]  = '{75, 1'b1, 0, 0, 1};
    vecs[3]  = '{19, 1'b0, 0, 0, 1};
    vecs[4]  = '{50, 1'b0, 0, 0, 1};
    vecs[5]  = '{91, 1'b0, 0, 0, 1};
    vecs[6]  = '{20, 1'b0, 1, 0, 0};
    vecs[7]  = '{40, 1'b0, 1, 0, 0};
    vecs[8]  = '{60, 1'b0, 0, 1, 0};
    vecs[9]  = '{90, 1'b0, 0, 1, 0};
    vecs[10] = '{41, 1'b0, 0, 0, 1};
    vecs[11] = '{59, 1'b1, 0, 0, 1};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_coin", coin_o, 0);
    check("rst_reject", reject_o, 0);
    check("rst_jam", jam_o, 0);
    check("rst_busy", busy_o, 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
`ifdef COIN_VALIDATOR_STATS_EN
    #1;
    check("rst_acc_cnt", acc_cnt_o, 0);
    check("rst_rej_cnt", rej_cnt_o, 0);
`endif

    // Vector table.
    foreach (vecs[i]) begin
      nm = $sformatf("vec%0d_w%0d_i%0d", i, vecs[i].width, vecs[i].inh);
      snap();
      inhibit_i = vecs[i].inh;
      drive_pulse(vecs[i].width);
      wait_idle(nm);
      check({nm, "_c50"}, n50 - s50, vecs[i].e50);
      check({nm, "_c100"}, n100 - s100, vecs[i].e100);
      check({nm, "_rej"}, nrej - srej, vecs[i].erej);
      check({nm, "_overlap"}, nbad - sbad, 0);
      if (vecs[i].e50 + vecs[i].e100 + vecs[i].erej > 0)
        check({nm, "_lockout"}, busy_fall_cyc - last_pulse_cyc, LOCK);
      note_model(vecs[i].e50 ? 1 : vecs[i].e100 ? 2 : 3);
    end
    inhibit_i = 1'b0;

    // 30-cycle coin with two 2-cycle dropouts.
    snap();
    @(posedge clk);
    for (int i = 0; i < 30; i++) begin
      #1 sens_i = !(i == 10 || i == 11 || i == 20 || i == 21);
      @(posedge clk);
    end
    #1 sens_i = 1'b0;
    wait_idle("glitch");
    check("glitch_c50", n50 - s50, 1);
    check("glitch_rej", nrej - srej, 0);
    note_model(1);

    // 3-cycle spike is filtered out.
    snap();
    drive_pulse(3);
    repeat (20) @(posedge clk);
    check("spike_busy_cycles", busy_cycles - sbusy, 0);
    check("spike_pulses", (n50 - s50) + (n100 - s100) + (nrej - srej), 0);

    // Stuck sensor.
    snap();
    drive_pulse(300);
    @(negedge clk);
    check("jam_level", jam_o, 1);
    check("jam_rise_delay", jam_rise_cyc - busy_rise_cyc, 254);
    repeat (SYNC + DEB + 2) @(posedge clk);
    @(negedge clk);
    check("jam_cleared", jam_o, 0);
    wait_idle("jam");
    check("jam_events", njam - sjam, 1);
    check("jam_pulses", (n50 - s50) + (n100 - s100) + (nrej - srej), 0);
    if (exp_rej < 255) exp_rej++;

    // Random run against the width model.
    for (int n = 0; n < 300; n++) begin
      w    = $urandom_range(1, 110);
      inh  = ($urandom_range(0, 3) == 0);
      code = model_code(w, inh);
      nm   = $sformatf("rnd%0d_w%0d_i%0d", n, w, inh);
      snap();
      inhibit_i = inh;
      drive_pulse(w);
      wait_idle(nm);
      check({nm, "_c50"}, n50 - s50, (code == 1) ? 1 : 0);
      check({nm, "_c100"}, n100 - s100, (code == 2) ? 1 : 0);
      check({nm, "_rej"}, nrej - srej, (code == 3) ? 1 : 0);
      check({nm, "_overlap"}, nbad - sbad, 0);
      note_model(code);
    end
    inhibit_i = 1'b0;
`ifdef COIN_VALIDATOR_STATS_EN
    #1;
    check("stats_acc_cnt", acc_cnt_o, exp_acc);
    check("stats_rej_cnt", rej_cnt_o, exp_rej);
`endif

    // Reset in the middle of a 30-cycle coin.
    snap();
    @(posedge clk); #1 sens_i = 1'b1;
    repeat (15) @(posedge clk);
    #2;
    check("midrst_busy_before", busy_o, 1);
    rst = 1'b1;
    #1;
    check("midrst_coin", coin_o, 0);
    check("midrst_reject", reject_o, 0);
    check("midrst_jam", jam_o, 0);
    check("midrst_busy", busy_o, 0);
`ifdef COIN_VALIDATOR_STATS_EN
    check("midrst_acc_cnt", acc_cnt_o, 0);
    check("midrst_rej_cnt", rej_cnt_o, 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sbusy = busy_cycles;
    repeat (13) @(posedge clk);
    #1 sens_i = 1'b0;
    repeat (60) @(posedge clk);
    check("midrst_no_pulse", (n50 - s50) + (n100 - s100) + (nrej - srej), 0);
    check("midrst_no_busy", busy_cycles - sbusy, 0);

    // A normal coin after the aborted one.
    snap();
    drive_pulse(30);
    wait_idle("post_rst");
    check("post_rst_c50", n50 - s50, 1);
    check("post_rst_rej", nrej - srej, 0);
`ifdef COIN_VALIDATOR_STATS_EN
    #1;
    check("post_rst_acc_cnt", acc_cnt_o, 1);
    check("post_rst_rej_cnt", rej_cnt_o, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
